// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - shares the DRAM command port between a write client and a read client
// Burst-limited, alternating grants with a bounded read-pending window and a drain before turnaround.
module dram_port_arbiter #(
    parameter int ADDR_WIDTH  = 15,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_BURST   = 16,
    parameter int MAX_PENDING = 8
) (
    input  logic                  dram_clk,
    input  logic                  dram_rst,
    input  logic                  wr_req,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_grant,
    output logic                  wr_ready,
    input  logic                  rd_req,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_grant,
    output logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  dram_ready,
    output logic                  dram_en,
    output logic                  dram_we,
    output logic [ADDR_WIDTH-1:0] dram_addr,
    output logic [DATA_WIDTH-1:0] dram_wdata,
    input  logic                  dram_rd_valid,
    input  logic [DATA_WIDTH-1:0] dram_rd_data,
    output logic                  busy,
    output logic                  err
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int PW = $clog2(MAX_PENDING + 1);

    typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

    state_t          state;
    logic            last_wr;
    logic [CW-1:0]   beat_cnt;
    logic [PW-1:0]   pending;

    logic            wr_acc;
    logic            rd_acc;
    logic            ret_ok;
    logic            burst_done;
    logic [CW-1:0]   cnt_next;
    logic [PW-1:0]   pending_next;

    assign wr_grant = (state == WR);
    assign rd_grant = (state == RD);
    assign wr_ready = wr_grant & dram_ready;
    assign rd_ready = rd_grant & dram_ready & (pending < PW'(MAX_PENDING));

    assign wr_acc = wr_ready & wr_en;
    assign rd_acc = rd_ready & rd_en;

    // A return with nothing outstanding is an error and must not wrap the counter.
    assign ret_ok       = dram_rd_valid & (pending != '0);
    assign pending_next = pending + PW'(rd_acc) - PW'(ret_ok);

    // Burst length counts the beat accepted this cycle, so the yield never lets an extra beat through.
    assign cnt_next   = beat_cnt + CW'(wr_acc | rd_acc);
    assign burst_done = (cnt_next == CW'(MAX_BURST));

    assign dram_en    = wr_acc | rd_acc;
    assign dram_we    = wr_acc;
    assign dram_addr  = wr_acc ? wr_addr : (rd_acc ? rd_addr : '0);
    assign dram_wdata = wr_acc ? wr_data : '0;

    assign busy = (state != IDLE) | (pending != '0);

    always_ff @(posedge dram_clk) begin
        if (dram_rst) begin
            state    <= IDLE;
            last_wr  <= 1'b0;
            beat_cnt <= '0;
            pending  <= '0;
            err      <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            pending  <= pending_next;
            rd_valid <= dram_rd_valid;
            rd_data  <= dram_rd_data;
            if (dram_rd_valid && (pending == '0)) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (wr_req && (!rd_req || !last_wr)) begin
                        state    <= WR;
                        last_wr  <= 1'b1;
                        beat_cnt <= '0;
                    end else if (rd_req) begin
                        state    <= RD;
                        last_wr  <= 1'b0;
                        beat_cnt <= '0;
                    end
                end
                WR: begin
                    if (!wr_req || (burst_done && rd_req)) begin
                        state <= IDLE;
                    end else if (burst_done) begin
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= cnt_next;
                    end
                end
                RD: begin
                    if (!rd_req || (burst_done && wr_req)) begin
                        state <= DRAIN;
                    end else if (burst_done) begin
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= cnt_next;
                    end
                end
                DRAIN: begin
                    if (pending_next == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - randomized and directed bench for dram_port_arbiter
// A behavioural port-ownership model is compared against the DUT every cycle.
module tb_dram_port_arbiter;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int MB = 16;
    localparam int MP = 8;

    logic          dram_clk = 1'b0;
    logic          dram_rst = 1'b1;
    logic          wr_req = 1'b0, wr_en = 1'b0, rd_req = 1'b0, rd_en = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          dram_ready = 1'b0, dram_rd_valid = 1'b0;
    logic [DW-1:0] dram_rd_data = '0;
    logic          wr_grant, wr_ready, rd_grant, rd_ready, rd_valid;
    logic [DW-1:0] rd_data, dram_wdata;
    logic          dram_en, dram_we, busy, err;
    logic [AW-1:0] dram_addr;

    int   total = 0;
    int   bad = 0;
    int   cyc_n = 0;
    int   lat = 4;
    logic spur = 1'b0;
    int   due_q[$];

    // Model: owner 0 = none, 1 = writer, 2 = reader, 3 = draining reads.
    int            m_own = 0;
    bit            m_last_wr = 1'b0;
    int            m_cnt = 0;
    int            m_pend = 0;
    bit            m_err = 1'b0;
    bit            m_rv = 1'b0;
    logic [DW-1:0] m_rd = '0;

    dram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .MAX_PENDING(MP)) dut (
        .dram_clk(dram_clk), .dram_rst(dram_rst),
        .wr_req(wr_req), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_grant(wr_grant), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_grant(rd_grant), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .dram_ready(dram_ready), .dram_en(dram_en), .dram_we(dram_we),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata),
        .dram_rd_valid(dram_rd_valid), .dram_rd_data(dram_rd_data),
        .busy(busy), .err(err)
    );

    always #5 dram_clk = ~dram_clk;
    always @(posedge dram_clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc_n, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge dram_clk);
        #1;
    endtask

    always @(negedge dram_clk) begin : compare
        bit            wacc, racc, ret;
        int            np;
        logic [AW-1:0] ea;
        wacc = (m_own == 1) && wr_en && dram_ready;
        racc = (m_own == 2) && rd_en && dram_ready && (m_pend < MP);
        ea   = wacc ? wr_addr : (racc ? rd_addr : '0);
        chk("wr_grant", wr_grant, m_own == 1);
        chk("rd_grant", rd_grant, m_own == 2);
        chk("wr_ready", wr_ready, (m_own == 1) && dram_ready);
        chk("rd_ready", rd_ready, (m_own == 2) && dram_ready && (m_pend < MP));
        chk("dram_en", dram_en, wacc || racc);
        chk("dram_we", dram_we, wacc);
        chk("dram_addr", dram_addr, ea);
        chk("dram_wdata", dram_wdata, wacc ? wr_data : '0);
        chk("busy", busy, (m_own != 0) || (m_pend != 0));
        chk("err", err, m_err);
        chk("rd_valid", rd_valid, m_rv);
        chk("rd_data", rd_data, m_rd);
        if (racc) due_q.push_back(cyc_n + lat);
        if (dram_rst) begin
            m_own = 0; m_last_wr = 1'b0; m_cnt = 0; m_pend = 0;
            m_err = 1'b0; m_rv = 1'b0; m_rd = '0;
        end else begin
            ret = dram_rd_valid;
            if (ret && m_pend == 0) m_err = 1'b1;
            np = m_pend + (racc ? 1 : 0) - ((ret && m_pend > 0) ? 1 : 0);
            case (m_own)
                0: begin
                    if (wr_req && (!rd_req || !m_last_wr)) begin
                        m_own = 1; m_last_wr = 1'b1; m_cnt = 0;
                    end else if (rd_req) begin
                        m_own = 2; m_last_wr = 1'b0; m_cnt = 0;
                    end
                end
                1: begin
                    m_cnt += int'(wacc);
                    if (!wr_req) m_own = 0;
                    else if (m_cnt == MB) begin
                        if (rd_req) m_own = 0;
                        m_cnt = 0;
                    end
                end
                2: begin
                    m_cnt += int'(racc);
                    if (!rd_req) m_own = 3;
                    else if (m_cnt == MB) begin
                        if (wr_req) m_own = 3;
                        m_cnt = 0;
                    end
                end
                default: if (np == 0) m_own = 0;
            endcase
            m_pend = np;
            m_rv = dram_rd_valid;
            m_rd = dram_rd_data;
        end
    end

    // DRAM return side: each issued read comes back after its latency, one per cycle.
    initial begin
        forever begin
            @(posedge dram_clk);
            #2;
            dram_rd_data = $urandom;
            if (due_q.size() > 0 && due_q[0] <= cyc_n) begin
                void'(due_q.pop_front());
                dram_rd_valid = 1'b1;
            end else begin
                dram_rd_valid = spur;
            end
        end
    end

    task automatic idle_inputs;
        wr_req = 1'b0; wr_en = 1'b0; rd_req = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_reset;
        tick();
        dram_rst = 1'b1;
        idle_inputs();
        dram_ready = 1'b0;
        tick();
        tick();
        dram_rst = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge dram_clk);
            if (!busy && due_q.size() == 0 && !rd_valid) break;
        end
        chk(nm, k < 300, 1'b1);
    endtask

    initial begin
        int n, rets, rc, wg, nb, c16, rg, fi, ni9, frv, nlow, rvn, acc;

        // Reset state
        @(negedge dram_clk);
        chk("reset_wr_grant", wr_grant, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_err", err, 1'b0);
        chk("reset_dram_en", dram_en, 1'b0);
        do_reset();

        // Writer only, five beats
        wr_req = 1'b1; dram_ready = 1'b1;
        @(negedge dram_clk);
        chk("wr_req_cycle_grant", wr_grant, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            wr_en = 1'b1; wr_addr = AW'(100 + i); wr_data = DW'(32'hA000 + i);
            @(negedge dram_clk);
            chk("wr_beat_grant", wr_grant, 1'b1);
            chk("wr_beat_en", dram_en, 1'b1);
            chk("wr_beat_addr", dram_addr, AW'(100 + i));
        end
        tick();
        wr_req = 1'b0; wr_en = 1'b0;
        @(negedge dram_clk);
        chk("wr_drop_same_cycle", wr_grant, 1'b1);
        tick();
        @(negedge dram_clk);
        chk("wr_drop_next_cycle", wr_grant, 1'b0);

        // Both request from reset: writer first, yields after 16 beats
        do_reset();
        wr_req = 1'b1; rd_req = 1'b1; wr_en = 1'b1; dram_ready = 1'b1;
        nb = 0; c16 = -1; rg = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge dram_clk);
            if (dram_en && dram_we) begin
                nb++;
                if (nb == 16) c16 = cyc_n;
            end
            if (rd_grant) begin rg = cyc_n; break; end
            tick();
            wr_addr = AW'($urandom); wr_data = $urandom;
        end
        chk("burst_beats", nb, 16);
        chk("burst_yield", rg, c16 + 2);
        tick();
        idle_inputs();
        wait_idle("burst_idle");

        // Reader, 10 beats, latency 12, pending window 8
        do_reset();
        lat = 12; rd_req = 1'b1; rd_en = 1'b1; dram_ready = 1'b1;
        n = 0; fi = -1; ni9 = -1; frv = -1; nlow = -1; rvn = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge dram_clk);
            if (dram_en && !dram_we) begin
                if (n == 0) fi = cyc_n;
                if (n == 8) ni9 = cyc_n;
                n++;
            end
            if (rd_grant && !rd_ready && nlow < 0) begin
                nlow = n;
                chk("model_pend_full", m_pend, MP);
            end
            if (rd_valid) begin
                if (rvn == 0) frv = cyc_n;
                rvn++;
            end
            if (n == 10 && rvn == 10) break;
            tick();
            rd_addr = AW'($urandom);
            if (n >= 10) begin rd_en = 1'b0; rd_req = 1'b0; end
        end
        chk("rd_stall_after", nlow, 8);
        chk("rd_resume", ni9, fi + 13);
        chk("rd_latency", frv, fi + 13);
        chk("rd_issued", n, 10);
        chk("rd_returned", rvn, 10);
        tick();
        idle_inputs();
        wait_idle("rd_idle");

        // Reader drops with 3 pending while writer waits
        do_reset();
        lat = 10; rd_req = 1'b1; rd_en = 1'b1; dram_ready = 1'b1;
        n = 0; rets = 0; rc = -1; wg = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge dram_clk);
            if (dram_en && !dram_we) n++;
            if (dram_rd_valid) begin
                rets++;
                if (rets == 3) rc = cyc_n;
            end
            if (wr_grant) begin wg = cyc_n; break; end
            tick();
            if (n >= 3) begin rd_req = 1'b0; rd_en = 1'b0; wr_req = 1'b1; wr_en = 1'b1; end
        end
        chk("drain_reads", n, 3);
        chk("drain_turnaround", wg, rc + 2);
        tick();
        idle_inputs();
        wait_idle("drain_idle");

        // dram_ready toggling: only accepted beats count toward the burst
        do_reset();
        wr_req = 1'b1; rd_req = 1'b1; wr_en = 1'b1; dram_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge dram_clk);
            if (dram_en && dram_we) acc++;
            if (rd_grant) break;
            tick();
            dram_ready = ~dram_ready;
        end
        chk("toggle_beats", acc, 16);
        tick();
        idle_inputs();
        dram_ready = 1'b1;
        wait_idle("toggle_idle");

        // Spurious return sets sticky err; reset mid-burst clears everything
        tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        @(negedge dram_clk);
        chk("spur_err", err, 1'b1);
        tick();
        wr_req = 1'b1; wr_en = 1'b1;
        tick();
        tick();
        @(negedge dram_clk);
        chk("err_sticky", err, 1'b1);
        chk("model_err", m_err, 1'b1);
        tick();
        dram_rst = 1'b1;
        tick();
        dram_rst = 1'b0; idle_inputs();
        @(negedge dram_clk);
        chk("rst_mid_grant", wr_grant, 1'b0);
        chk("rst_mid_en", dram_en, 1'b0);
        chk("rst_mid_err", err, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 31) == 0) wr_req = ~wr_req;
            if ($urandom_range(0, 31) == 0) rd_req = ~rd_req;
            wr_en      = ($urandom_range(0, 3) != 0);
            rd_en      = ($urandom_range(0, 3) != 0);
            dram_ready = ($urandom_range(0, 3) != 0);
            wr_addr    = AW'($urandom);
            rd_addr    = AW'($urandom);
            wr_data    = $urandom;
            lat        = $urandom_range(1, 20);
            dram_rst   = ($urandom_range(0, 499) == 0);
        end
        tick();
        dram_rst = 1'b0;
        idle_inputs();
        wait_idle("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Arbiter that shares the single DRAM command port between one write client (the DRAM write path) and one read client, in the DRAM clock domain. It grants the port in bursts, alternates fairly when both clients request, limits outstanding reads, and drains in-flight reads before the port can turn around to writes. It sits between the write/read engines and the DRAM controller interface.

## Interface
- ADDR_WIDTH, 15, DRAM word address width
- DATA_WIDTH, 32, DRAM data width
- MAX_BURST, 16, beats per grant before yielding to a waiting client (≥1)
- MAX_PENDING, 8, maximum outstanding read beats (≥1)

- dram_clk  in  1  sole clock; all logic on rising edge
- dram_rst  in  1  synchronous, active-high reset
- wr_req  in  1  write client wants the port
- wr_en  in  1  write beat valid
- wr_addr  in  ADDR_WIDTH  write beat address
- wr_data  in  DATA_WIDTH  write beat data
- wr_grant  out  1  port owned by write client
- wr_ready  out  1  write beat accepted when wr_en & wr_ready
- rd_req  in  1  read client wants the port
- rd_en  in  1  read beat valid
- rd_addr  in  ADDR_WIDTH  read beat address
- rd_grant  out  1  port owned by read client
- rd_ready  out  1  read beat accepted when rd_en & rd_ready
- rd_valid  out  1  returned read data valid (registered)
- rd_data  out  DATA_WIDTH  returned read data (registered)
- dram_ready  in  1  DRAM accepts a command this cycle
- dram_en  out  1  command issue strobe
- dram_we  out  1  1 = write, 0 = read
- dram_addr  out  ADDR_WIDTH  command address
- dram_wdata  out  DATA_WIDTH  write data
- dram_rd_valid  in  1  read return valid
- dram_rd_data  in  DATA_WIDTH  read return data
- busy  out  1  state ≠ IDLE or pending ≠ 0
- err  out  1  sticky: read return with pending = 0

## Operation
- States: IDLE, WR, RD, DRAIN. wr_grant = (state==WR), rd_grant = (state==RD).
- IDLE: one requester → its state next cycle. Both → client not granted last (last_grant register, reset value RD, so writer wins first). Neither → stay.
- WR: wr_ready = dram_ready. Accepted beat: dram_en=1, dram_we=1, dram_addr=wr_addr, dram_wdata=wr_data (combinational pass-through); beat_cnt++.
- RD: rd_ready = dram_ready & (pending < MAX_PENDING). Accepted beat: dram_en=1, dram_we=0, dram_addr=rd_addr, dram_wdata=0; beat_cnt++, pending++.
- Exit WR→IDLE / RD→DRAIN when wr_req/rd_req sampled 0, or when beat_cnt reaches MAX_BURST and the other client requests. If beat_cnt reaches MAX_BURST with no competing request, beat_cnt resets to 0 and grant holds.
- beat_cnt clears on entry to WR/RD; width clog2(MAX_BURST+1).
- DRAIN: no grants; returns still counted; go IDLE when pending==0. Minimum one cycle.
- pending: +1 on read issue, −1 on dram_rd_valid; simultaneous → unchanged. dram_rd_valid with pending==0: no decrement, err←1.
- rd_valid/rd_data: dram_rd_valid/dram_rd_data registered one cycle, forwarded in every state.
- Outside accepted beats: dram_en=0, dram_we=0, dram_addr=0, dram_wdata=0.

## Timing
- Reset: state=IDLE, last_grant=RD, beat_cnt=0, pending=0, err=0, rd_valid=0, rd_data=0; therefore all grants/ready/dram_* outputs 0, busy=0.
- Request in IDLE at cycle t → grant at t+1; beat may be accepted in t+1.
- Turnaround: exit condition at t → grant low at t+1 (IDLE or DRAIN) → next grant earliest t+2 (after WR) or cycle after pending reaches 0 (after RD).
- Read return latency arbitrary; rd_valid = dram_rd_valid delayed exactly 1 cycle.
- Reset mid-operation: all state discarded; returns of pre-reset reads are forwarded and set err.

## Test plan
- Writer only, 5 beats, dram_ready=1 → wr_grant at t+1, 5 dram_en with dram_we=1, addr/data match; wr_req low → grant drops next cycle.
- Both request from reset → writer granted first; writer holds 20 beats with MAX_BURST=16 → yields after beat 16, rd_grant 2 cycles later.
- Reader issues 10 beats, MAX_PENDING=8, DRAM return latency 12 → rd_ready low after 8th issue, resumes on first return; rd_valid 13 cycles after each issue.
- Reader drops rd_req with 3 pending, writer requesting → DRAIN until 3rd return, then IDLE, then wr_grant; no write issued while pending>0.
- dram_ready toggling 1/0 during write burst → beats accepted only when ready; beat_cnt counts accepted beats only.
- Spurious dram_rd_valid at pending=0 → err=1 sticky; dram_rst mid-burst → all outputs 0 next cycle, err cleared.
